prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter instructionSize, default 24, instruction width in bits (multiple of 8).
REQ-002 SHALL have parameter memDepth, default 256, instruction-memory words.
REQ-003 SHALL have parameter addrBits, default 8, log2(memDepth).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle load command, sampled in IDLE, DONE and ERR.
REQ-007 SHALL have port count  input  addrBits+1  number of instructions to load, sampled with start.
REQ-008 SHALL have port byte_valid  input  1  host byte strobe.
REQ-009 SHALL have port byte_data  input  8  host byte.
REQ-010 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-012 SHALL have port imem_addr  output  addrBits  write address.
REQ-013 SHALL have port imem_wdata  output  instructionSize  assembled instruction.
REQ-014 SHALL have port cpu_rst_n  output  1  processor release; 0 holds the processor in reset.
REQ-015 SHALL have ports busy, done, err  output  1 each  status flags.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, WRITE, DONE, ERR.
REQ-017 IDLE/DONE/ERR + start with 1 <= count <= memDepth SHALL go to RECV, clear address counter and byte counter, latch count.
REQ-018 start with count == 0 or count > memDepth SHALL go to ERR; err=1.
REQ-019 start while in RECV or WRITE SHALL be ignored.
REQ-020 byte_ready SHALL be 1 only in RECV; a byte transfers when byte_valid && byte_ready.
REQ-021 Bytes SHALL pack MSB first: first byte -> imem_wdata[instructionSize-1 -: 8].
REQ-022 On the transfer of the (instructionSize/8)-th byte, FSM SHALL go to WRITE next cycle.
REQ-023 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=current word index, imem_wdata=assembled word.
REQ-024 After WRITE, address SHALL increment; if incremented address == latched count go to DONE, else RECV with byte counter cleared.
REQ-025 Per-instruction latency: last byte accepted in cycle N -> imem_we high in cycle N+1 -> byte_ready high again in N+2.
REQ-026 byte_valid gaps SHALL stall RECV indefinitely without losing assembled bytes.
REQ-027 imem_we SHALL be 0 in every state except WRITE.
REQ-028 busy SHALL be 1 exactly in RECV and WRITE.
REQ-029 DONE SHALL drive done=1 and cpu_rst_n=1; all other states drive cpu_rst_n=0, done=0.
REQ-030 A new start from DONE SHALL drop cpu_rst_n to 0 in the next cycle (reload re-halts processor).
REQ-031 Address counter SHALL never exceed memDepth-1 at imem_we; no wrap-around write occurs.
REQ-032 err SHALL stay 1 in ERR until a valid start moves the FSM to RECV.

Reset
REQ-033 rst low SHALL immediately force IDLE, imem_we=0, imem_addr=0, imem_wdata=0, byte_ready=0, busy=0, done=0, err=0, cpu_rst_n=0.
REQ-034 rst asserted mid-load SHALL abandon the load; no further imem_we until a new start.

Structure
REQ-035 Shared package simd_pkg SHALL hold instructionSize default and the loader state enum type.
REQ-036 Byte-to-word packing SHALL live in one sub-module byte_packer (shift register plus byte counter, clear and full outputs).

Verification
REQ-037 count=2, bytes 12 34 56 AB CD EF back-to-back -> imem writes addr0=0x123456, addr1=0xABCDEF; done=1, cpu_rst_n=1 on the cycle after second write.
REQ-038 count=1, bytes with 3-cycle byte_valid gaps -> single write 0x... correct, byte_ready held high throughout gaps.
REQ-039 start with count=0 and with count=257 -> err=1, no imem_we, cpu_rst_n=0; subsequent start count=1 clears err.
REQ-040 start pulsed during RECV with count=5 -> ignored, original count=2 load completes normally.
REQ-041 rst low after 4 bytes of count=2 load -> immediate IDLE, outputs at reset values, no write of partial word.
REQ-042 start count=1 from DONE -> cpu_rst_n falls next cycle, rises after new write completes.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared definitions for the program loader: default instruction width,
// loader state encoding and the per-state output flag set.
package simd_pkg;

   localparam int INSTRUCTION_SIZE_DEFAULT = 24;

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      WRITE,
      DONE,
      ERR
   } loader_state_t;

   // Every status output is a pure function of the state being entered,
   // so the FSM loads this struct on the same edge as the state register.
   typedef struct packed {
      logic byte_ready;
      logic imem_we;
      logic busy;
      logic done;
      logic err;
      logic cpu_rst_n;
   } loader_flags_t;

   function automatic loader_flags_t state_flags(input loader_state_t s);
      loader_flags_t f;
      f = '0;
      case (s)
         RECV:  begin f.byte_ready = 1'b1; f.busy = 1'b1; end
         WRITE: begin f.imem_we = 1'b1; f.busy = 1'b1; end
         DONE:  begin f.done = 1'b1; f.cpu_rst_n = 1'b1; end
         ERR:   f.err = 1'b1;
         default: ;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream plus instruction-memory write port of the program loader.
interface prog_loader_if #(
   parameter int instructionSize = 24,
   parameter int addrBits        = 8
);
   logic                       byte_valid;
   logic [7:0]                 byte_data;
   logic                       byte_ready;
   logic                       imem_we;
   logic [addrBits-1:0]        imem_addr;
   logic [instructionSize-1:0] imem_wdata;

   // Host / bench side: supplies bytes, observes the memory writes.
   modport master (
      output byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata
   );

   // Loader side: consumes bytes, drives the memory write port.
   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Assembles consecutive bytes into one instruction word, first byte ending
// up in the most significant position.
module byte_packer #(
   parameter int instructionSize = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       shift,
   input  logic [7:0]                 byte_in,
   output logic [instructionSize-1:0] word,
   output logic                       full
);
   localparam int BYTES = instructionSize / 8;
   localparam int CW    = $clog2(BYTES + 1);

   logic [CW-1:0] cnt;

   // Flags the byte that completes the word, in the cycle it is accepted,
   // so the FSM can enter WRITE on that very edge.
   assign full = shift && (cnt == CW'(BYTES - 1));

   // Shift register and byte counter; counter restarts on clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word <= '0;
         cnt  <= '0;
      end else begin
         // NOTE: state flops use non-blocking assignments so every flop in
         // the design samples pre-edge values regardless of block order.
         if (clear)
            cnt <= '0;
         else if (shift)
            cnt <= cnt + 1'b1;
         if (shift)
            word <= (word << 8) | instructionSize'(byte_in);
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream from the host, packs it into
// instructions, writes them to instruction memory and then releases the CPU.
module prog_loader
   import simd_pkg::*;
#(
   parameter int instructionSize = INSTRUCTION_SIZE_DEFAULT,
   parameter int memDepth        = 256,
   parameter int addrBits        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [addrBits:0] count,
   prog_loader_if.slave      bus,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam logic [addrBits:0] DEPTH = (addrBits + 1)'(memDepth);

   loader_state_t              state;
   loader_flags_t              flags;
   logic [addrBits-1:0]        addr;
   logic [addrBits:0]          total;
   logic [instructionSize-1:0] word;
   logic                       xfer;
   logic                       word_full;
   logic                       count_ok;
   logic                       launch;
   logic                       pack_clear;

   assign xfer       = bus.byte_valid && flags.byte_ready;
   assign count_ok   = (count != '0) && (count <= DEPTH);
   assign launch     = start && (state == IDLE || state == DONE || state == ERR);
   // Byte counter restarts for every fresh load and after every word write.
   assign pack_clear = (launch && count_ok) || (state == WRITE);

   byte_packer #(
      .instructionSize(instructionSize)
   ) u_packer (
      .clk    (clk),
      .rst    (rst),
      .clear  (pack_clear),
      .shift  (xfer),
      .byte_in(bus.byte_data),
      .word   (word),
      .full   (word_full)
   );

   assign bus.byte_ready = flags.byte_ready;
   assign bus.imem_we    = flags.imem_we;
   assign bus.imem_addr  = addr;
   assign bus.imem_wdata = word;
   assign cpu_rst_n      = flags.cpu_rst_n;
   assign busy           = flags.busy;
   assign done           = flags.done;
   assign err            = flags.err;

   // Load sequencer with registered status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: every control flop is reset here, so an abort mid-load
         // leaves no stale address, count or pending write behind.
         state <= IDLE;
         flags <= state_flags(IDLE);
         addr  <= '0;
         total <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  if (count_ok) begin
                     state <= RECV;
                     flags <= state_flags(RECV);
                     addr  <= '0;
                     total <= count;
                  end else begin
                     state <= ERR;
                     flags <= state_flags(ERR);
                  end
               end
            end
            RECV: begin
               if (xfer && word_full) begin
                  state <= WRITE;
                  flags <= state_flags(WRITE);
               end
            end
            WRITE: begin
               addr <= addr + 1'b1;
               if (({1'b0, addr} + 1'b1) == total) begin
                  state <= DONE;
                  flags <= state_flags(DONE);
               end else begin
                  state <= RECV;
                  flags <= state_flags(RECV);
               end
            end
            default: begin
               state <= IDLE;
               flags <= state_flags(IDLE);
            end
         endcase
      end
   end

endmodule
